// File: rtl/pe_tile_scheduler.sv
// Sequences one bit-plane PE through num_k K tiles and returns the saturated
// element-wise sum of the PE result tiles over a valid/ready output port.
module pe_tile_scheduler #(
  parameter int TILE_SIZE      = 4,
  parameter int RESULT_WIDTH   = 32,
  parameter int ACC_WIDTH      = 40,
  parameter int KT_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        cmd_valid,
  output logic                                        cmd_ready,
  input  logic [KT_WIDTH-1:0]                         cmd_num_k,
  input  logic [7:0]                                  cmd_threshold,
  output logic                                        ld_valid,
  output logic [KT_WIDTH-1:0]                         ld_k_idx,
  input  logic                                        ld_ready,
  output logic                                        pe_rst_n,
  output logic                                        pe_start,
  output logic [7:0]                                  pe_threshold,
  input  logic                                        pe_done,
  input  logic [TILE_SIZE*TILE_SIZE*RESULT_WIDTH-1:0] pe_result,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0]    out_tile,
  output logic                                        out_sat,
  output logic                                        out_err,
  output logic                                        busy
);

  localparam int NUM_ELEM    = TILE_SIZE * TILE_SIZE;
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PE_CLR = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_OUTPUT = 3'd5;

  logic [2:0]             state;
  logic [KT_WIDTH-1:0]    num_k;
  logic [KT_WIDTH-1:0]    kidx;
  logic [TIMER_WIDTH-1:0] timer;
  logic [7:0]             threshold;
  logic                   sat;
  logic                   err;
  logic                   pe_rst_q;
  logic [ACC_WIDTH-1:0]   acc      [NUM_ELEM];
  logic [ACC_WIDTH-1:0]   acc_next [NUM_ELEM];
  logic [ACC_WIDTH:0]     sum      [NUM_ELEM];
  logic [NUM_ELEM-1:0]    elem_sat;

  // One guard bit is enough: a disagreement between the top two sum bits marks overflow.
  always_comb begin
    elem_sat = '0;
    for (int e = 0; e < NUM_ELEM; e++) begin
      sum[e] = {acc[e][ACC_WIDTH-1], acc[e]}
             + {{(ACC_WIDTH-RESULT_WIDTH+1){pe_result[e*RESULT_WIDTH+RESULT_WIDTH-1]}},
                pe_result[e*RESULT_WIDTH +: RESULT_WIDTH]};
      acc_next[e] = sum[e][ACC_WIDTH-1:0];
      if (sum[e][ACC_WIDTH] != sum[e][ACC_WIDTH-1]) begin
        elem_sat[e] = 1'b1;
        acc_next[e] = sum[e][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      num_k     <= '0;
      kidx      <= '0;
      timer     <= '0;
      threshold <= '0;
      sat       <= 1'b0;
      err       <= 1'b0;
      pe_rst_q  <= 1'b0;
      for (int e = 0; e < NUM_ELEM; e++) acc[e] <= '0;
    end else begin
      // pe_rst_n is registered, so it is pulled low on the edge that enters PE_CLR.
      pe_rst_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            num_k     <= cmd_num_k;
            threshold <= cmd_threshold;
            kidx      <= '0;
            sat       <= 1'b0;
            err       <= 1'b0;
            for (int e = 0; e < NUM_ELEM; e++) acc[e] <= '0;
            if (cmd_num_k == '0) begin
              state <= S_OUTPUT;
            end else begin
              state    <= S_PE_CLR;
              pe_rst_q <= 1'b0;
            end
          end
        end
        S_PE_CLR: state <= S_LOAD;
        S_LOAD: begin
          if (ld_ready) state <= S_START;
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (pe_done) begin
            for (int e = 0; e < NUM_ELEM; e++) acc[e] <= acc_next[e];
            if (|elem_sat) sat <= 1'b1;
            kidx <= kidx + 1'b1;
            if (kidx == num_k - 1'b1) begin
              state <= S_OUTPUT;
            end else begin
              state    <= S_PE_CLR;
              pe_rst_q <= 1'b0;
            end
          end else if (timer == TIMER_LAST) begin
            err   <= 1'b1;
            state <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced to their idle values for as long as rst_n is held low.
  assign cmd_ready    = rst_n && (state == S_IDLE);
  assign busy         = rst_n && (state != S_IDLE);
  assign ld_valid     = rst_n && (state == S_LOAD);
  assign pe_start     = rst_n && (state == S_START);
  assign out_valid    = rst_n && (state == S_OUTPUT);
  assign ld_k_idx     = rst_n ? kidx : '0;
  assign pe_threshold = rst_n ? threshold : '0;
  assign pe_rst_n     = rst_n && pe_rst_q;
  assign out_sat      = rst_n && sat;
  assign out_err      = rst_n && err;

  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_out
    assign out_tile[e*ACC_WIDTH +: ACC_WIDTH] = rst_n ? acc[e] : '0;
  end

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Randomized self-checking bench for pe_tile_scheduler with a behavioural PE/loader
// responder and an arithmetic reference model of the accumulated tile.
module tb_pe_tile_scheduler;
  localparam int TS = 4;
  localparam int RW = 32;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int TO = 64;
  localparam int NE = TS * TS;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [KW-1:0]    cmd_num_k;
  logic [7:0]       cmd_threshold;
  logic             ld_valid;
  logic [KW-1:0]    ld_k_idx;
  logic             ld_ready;
  logic             pe_rst_n;
  logic             pe_start;
  logic [7:0]       pe_threshold;
  logic             pe_done;
  logic [NE*RW-1:0] pe_result;
  logic             out_valid;
  logic             out_ready;
  logic [NE*AW-1:0] out_tile;
  logic             out_sat;
  logic             out_err;
  logic             busy;

  pe_tile_scheduler #(
    .TILE_SIZE(TS), .RESULT_WIDTH(RW), .ACC_WIDTH(AW), .KT_WIDTH(KW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_k(cmd_num_k),
    .cmd_threshold(cmd_threshold),
    .ld_valid(ld_valid), .ld_k_idx(ld_k_idx), .ld_ready(ld_ready),
    .pe_rst_n(pe_rst_n), .pe_start(pe_start), .pe_threshold(pe_threshold),
    .pe_done(pe_done), .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile),
    .out_sat(out_sat), .out_err(out_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder configuration and per-K-tile PE results, written by the stimulus.
  logic [RW-1:0] res_tab [0:255][0:NE-1];
  int            ld_delay [0:255];
  int            pe_lat;
  int            hang_k;

  int checks = 0;
  int errors = 0;

  // Loader and PE responder; drives 1 unit after each rising edge, noise when idle.
  initial begin : pe_model
    int  cur_k, pe_cnt, ld_cnt;
    bit  pe_busy, pe_hung;
    cur_k = 0; pe_cnt = 0; ld_cnt = 0; pe_busy = 0; pe_hung = 0;
    ld_ready = 1'b0; pe_done = 1'b0; pe_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ld_valid === 1'b1) begin
        ld_ready = (ld_cnt >= ld_delay[ld_k_idx]);
        ld_cnt++;
        if (ld_ready) cur_k = int'(ld_k_idx);
      end else begin
        ld_cnt   = 0;
        ld_ready = 1'($urandom);
      end
      if (pe_start === 1'b1) begin
        pe_busy = 1; pe_cnt = 0; pe_hung = (cur_k >= hang_k); pe_done = 1'b0;
      end else if (pe_busy) begin
        pe_cnt++;
        if (!pe_hung && pe_cnt == pe_lat) begin
          pe_done = 1'b1;
          for (int e = 0; e < NE; e++) pe_result[e*RW +: RW] = res_tab[cur_k][e];
          pe_busy = 0;
        end else begin
          pe_done = 1'b0;
          for (int e = 0; e < NE; e++) pe_result[e*RW +: RW] = RW'($urandom);
        end
      end else begin
        pe_done = 1'($urandom);
        for (int e = 0; e < NE; e++) pe_result[e*RW +: RW] = RW'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic setup(input int lat, input int hk);
    pe_lat = lat;
    hang_k = hk;
    for (int i = 0; i < 256; i++) ld_delay[i] = 0;
  endtask

  task automatic fill_const(input int nk, input logic [RW-1:0] v);
    for (int k = 0; k < nk; k++)
      for (int e = 0; e < NE; e++) res_tab[k][e] = v;
  endtask

  task automatic fill_rand(input int nk, input bit big);
    for (int k = 0; k < nk; k++)
      for (int e = 0; e < NE; e++)
        res_tab[k][e] = big ? RW'($urandom) : RW'(int'($urandom_range(2000)) - 1000);
  endtask

  // Reference: plain signed sums over the completed tiles, clamped after every tile.
  task automatic model_sum(input int n_done, output logic [NE*AW-1:0] tile, output bit sat);
    longint amax, amin, a;
    amax = (longint'(1) <<< (AW - 1)) - 1;
    amin = -(longint'(1) <<< (AW - 1));
    sat  = 0;
    tile = '0;
    for (int e = 0; e < NE; e++) begin
      a = 0;
      for (int k = 0; k < n_done; k++) begin
        a = a + longint'(signed'(res_tab[k][e]));
        if (a > amax) begin a = amax; sat = 1; end
        else if (a < amin) begin a = amin; sat = 1; end
      end
      tile[e*AW +: AW] = a[AW-1:0];
    end
  endtask

  task automatic run_cmd(input string tag, input int nk, input logic [7:0] thr, input int hold);
    logic [NE*AW-1:0] exp_tile;
    bit exp_sat, exp_err;
    int done_k, n_start, exp_lat, lat, limit, starts, clrs, rdy_busy, bad, unstable;
    int ld_q[$];
    exp_err = (hang_k < nk);
    done_k  = exp_err ? hang_k : nk;
    n_start = exp_err ? done_k + 1 : done_k;
    model_sum(done_k, exp_tile, exp_sat);
    exp_lat = 1 + done_k * (3 + pe_lat);
    for (int k = 0; k < done_k; k++) exp_lat += ld_delay[k];
    if (exp_err) exp_lat += 3 + ld_delay[hang_k] + TO;
    limit = exp_lat + 40;

    cmd_valid = 1'b1; cmd_num_k = KW'(nk); cmd_threshold = thr;
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_num_k = KW'($urandom); cmd_threshold = 8'($urandom);
    lat = 1; starts = 0; clrs = 0; rdy_busy = 0;
    forever begin
      if (pe_start === 1'b1) starts++;
      if (pe_rst_n === 1'b0) clrs++;
      if (cmd_ready !== 1'b0) rdy_busy++;
      if (ld_valid === 1'b1 && ld_ready === 1'b1) ld_q.push_back(int'(ld_k_idx));
      if (out_valid === 1'b1 || lat >= limit) break;
      out_ready = 1'($urandom);
      step();
      lat++;
    end
    out_ready = 1'b0;
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".out_tile"}, out_tile, exp_tile);
    check({tag, ".out_sat"}, out_sat, exp_sat);
    check({tag, ".out_err"}, out_err, exp_err);
    check({tag, ".pe_threshold"}, pe_threshold, thr);
    check({tag, ".pe_start_pulses"}, starts, n_start);
    check({tag, ".pe_rst_pulses"}, clrs, n_start);
    check({tag, ".ready_while_busy"}, rdy_busy, 0);
    bad = (ld_q.size() == n_start) ? 0 : 1;
    foreach (ld_q[i]) if (ld_q[i] != i) bad++;
    check({tag, ".ld_sequence"}, bad, 0);

    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = (h == 2);
      cmd_num_k = KW'($urandom_range(1, 255));
      step();
      if (out_valid !== 1'b1 || out_tile !== exp_tile || out_sat !== exp_sat ||
          out_err !== exp_err || cmd_ready !== 1'b0) unstable++;
    end
    cmd_valid = 1'b0;
    if (hold > 0) check({tag, ".hold_stable"}, unstable, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check({tag, ".idle_after"}, {busy, out_valid, cmd_ready}, 3'b001);
  endtask

  initial begin : stimulus
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_num_k = '0; cmd_threshold = '0; out_ready = 1'b0;
    setup(5, 999);

    // Power-up reset.
    step();
    step();
    check("rst.cmd_ready", cmd_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.ld_valid", ld_valid, 0);
    check("rst.pe_start", pe_start, 0);
    check("rst.pe_rst_n", pe_rst_n, 0);
    check("rst.out_tile", out_tile, 0);
    check("rst.flags", {out_sat, out_err}, 0);
    check("rst.pe_threshold", pe_threshold, 0);
    check("rst.ld_k_idx", ld_k_idx, 0);
    rst_n = 1'b1;
    #1;
    check("rst.first_idle_ready", cmd_ready, 1);
    step();
    check("rst.pe_rst_release", pe_rst_n, 1);

    // Each K tile returns k+1; three tiles sum to 6.
    setup(5, 999);
    for (int k = 0; k < 3; k++) fill_const(k + 1, RW'(k + 1));
    for (int k = 0; k < 3; k++) for (int e = 0; e < NE; e++) res_tab[k][e] = RW'(k + 1);
    run_cmd("basic", 3, 8'd2, 0);

    // Positive and negative saturation, then saturation staying sticky.
    setup(3, 999);
    fill_const(2, 32'h7FFF_FFFF);
    run_cmd("sat_pos", 2, 8'h11, 0);
    fill_const(2, 32'h8000_0000);
    run_cmd("sat_neg", 2, 8'hF0, 0);
    fill_const(3, 32'h7FFF_FFFF);
    fill_const(1, 32'h7FFF_FFFF);
    for (int e = 0; e < NE; e++) res_tab[2][e] = 32'hFFFF_FFFB;
    run_cmd("sat_sticky", 3, 8'h80, 0);

    // PE hangs on the second tile: timeout with the first tile's partial sum.
    setup(5, 1);
    fill_const(2, 32'd7);
    run_cmd("timeout", 2, 8'h33, 0);

    // Done on the last allowed WAIT cycle wins over the timeout.
    setup(TO, 999);
    fill_rand(1, 0);
    run_cmd("done_at_limit", 1, 8'h44, 0);

    // Output held for 10 cycles with a stray command offered meanwhile, then re-offered.
    setup(4, 999);
    fill_rand(2, 0);
    run_cmd("hold", 2, 8'h55, 10);
    fill_rand(3, 0);
    run_cmd("reoffer", 3, 8'h66, 0);

    // Zero-tile command straight to OUTPUT, then a slow loader on k=1.
    setup(4, 999);
    run_cmd("num_k_zero", 0, 8'h77, 1);
    setup(5, 999);
    ld_delay[1] = 4;
    fill_rand(2, 0);
    run_cmd("ld_delay", 2, 8'h08, 0);

    // Randomized commands.
    for (int r = 0; r < 6; r++) begin
      setup(int'($urandom_range(1, 10)), 999);
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) ld_delay[k] = int'($urandom_range(0, 3));
      fill_rand(n, 1'($urandom));
      run_cmd($sformatf("rand%0d", r), n, 8'($urandom), int'($urandom_range(0, 3)));
    end

    // Largest tile count must finish without index wrap.
    setup(1, 999);
    fill_rand(255, 1);
    run_cmd("num_k_max", 255, 8'hA5, 0);

    // Reset while waiting on the first tile abandons the command.
    setup(5, 999);
    fill_rand(2, 0);
    cmd_valid = 1'b1; cmd_num_k = 8'd2; cmd_threshold = 8'h5A;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (pe_start !== 1'b1 && n < 20) begin step(); n++; end
    check("rst_mid.start_seen", pe_start, 1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid.during", {cmd_ready, busy, out_valid, pe_rst_n}, 4'b0000);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_mid.after_ctrl", {cmd_ready, busy, out_valid, ld_valid, pe_start, pe_rst_n}, 6'b100000);
    check("rst_mid.after_data", {out_tile, out_sat, out_err, pe_threshold, ld_k_idx}, 0);
    step();
    check("rst_mid.pe_rst_release", {pe_rst_n, busy}, 2'b10);
    fill_rand(3, 0);
    run_cmd("after_rst", 3, 8'h3C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_tile_scheduler.md
Name: pe_tile_scheduler

Overview:
Sequences one bit-plane processing element (PE) through a K-tiled matrix product. It accepts a command giving the number of K tiles. For each K tile it clears the PE, requests operand loading, pulses start and waits for done. PE result tiles are accumulated in wider saturating accumulators, and one summed tile is returned per command over a valid/ready output.

Parameters:
TILE_SIZE, 4, PE tile dimension (TILE_SIZE x TILE_SIZE outputs)
RESULT_WIDTH, 32, width of each PE result element
ACC_WIDTH, 40, width of each accumulator element; must be >= RESULT_WIDTH
KT_WIDTH, 8, width of the K-tile count and index
TIMEOUT_CYCLES, 64, maximum WAIT cycles allowed before a PE is declared hung

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_num_k  in  KT_WIDTH  number of K tiles to accumulate
cmd_threshold  in  8  signed activation sparsity threshold for this command
ld_valid  out  1  operand load request for ld_k_idx
ld_k_idx  out  KT_WIDTH  K-tile index to load
ld_ready  in  1  loader has driven PE operands; it holds them stable until the next ld_valid
pe_rst_n  out  1  PE reset, active-low, registered
pe_start  out  1  one-cycle PE start pulse
pe_threshold  out  8  registered copy of cmd_threshold
pe_done  in  1  PE done
pe_result  in  TILE_SIZE*TILE_SIZE*RESULT_WIDTH  flattened PE result, element (i,j) at index i*TILE_SIZE+j
out_valid  out  1  accumulated tile available
out_ready  in  1  consumer accepts
out_tile  out  TILE_SIZE*TILE_SIZE*ACC_WIDTH  flattened accumulated tile, same element ordering
out_sat  out  1  at least one element saturated during this command
out_err  out  1  PE timeout occurred; out_tile holds a partial sum
busy  out  1  state != IDLE

Behaviour:
- Reset: while rst_n=0 at clk, the block goes to IDLE. Accumulators, kidx and timer clear to 0. The following are 0 during reset: out_valid, out_tile, out_sat, out_err, pe_start, ld_valid, ld_k_idx, pe_threshold, busy. pe_rst_n=0 while in reset. cmd_ready=0 while in reset and =1 on the first IDLE cycle after reset. Reset mid-operation abandons the command; no output is produced.
- States: IDLE, PE_CLR, LOAD, START, WAIT, OUTPUT.
- IDLE: cmd_ready=1. On cmd_valid, capture num_k and threshold, clear accumulators, out_sat and out_err, set kidx=0.
  - If num_k=0, go to OUTPUT with an all-zero tile.
  - Otherwise go to PE_CLR.
- PE_CLR: pe_rst_n=0 for exactly this one cycle, then LOAD.
- LOAD: ld_valid=1, ld_k_idx=kidx. Stays until ld_ready=1, then START. ld_ready outside LOAD is ignored.
- START: pe_start=1 for exactly one cycle, timer=0, then WAIT.
- WAIT: timer increments each cycle. When pe_done=1:
  - Accumulate acc[e] += sign-extend(pe_result[e]) for every element e, then increment kidx.
  - If kidx was num_k-1, go to OUTPUT; otherwise go to PE_CLR.
  - pe_done outside WAIT is ignored.
- Timeout: if pe_done is still 0 on the TIMEOUT_CYCLES-th WAIT cycle, set out_err=1 and go to OUTPUT with the partial accumulators. If pe_done=1 in that same cycle, done wins and no error is raised.
- Saturation: per element, signed, at ACC_WIDTH. A sum above the maximum clamps to 2^(ACC_WIDTH-1)-1; a sum below the minimum clamps to -2^(ACC_WIDTH-1). Any clamp sets out_sat, which stays set until the next command is accepted.
- OUTPUT: out_valid=1. out_tile, out_sat and out_err are held stable until out_ready=1, then IDLE. cmd_valid is ignored while not in IDLE.
- Latency: let L be the cycles from pe_start to pe_done. With ld_ready tied to 1, command accepted in cycle c gives out_valid first high in cycle c+1+num_k*(3+L). num_k=0 gives out_valid at c+1.
- Counters: kidx and the loop bound are KT_WIDTH bits. num_k = 2^KT_WIDTH-1 completes without wrap.

Test Plan:
- PE model with L=5 returning every element = k_idx+1; num_k=3, threshold=2 -> pe_threshold=2, ld_k_idx sequence 0,1,2, three pe_rst_n low pulses and three pe_start pulses, out_tile all elements=6 at c+25, out_sat=0, out_err=0.
- ACC_WIDTH=32 with two tiles of 0x7FFFFFFF -> all elements 0x7FFFFFFF, out_sat=1; repeat with 0x80000000 -> 0x80000000, out_sat=1.
- PE model never asserts done, num_k=2, first tile returns 7 -> out_err=1, out_tile all elements=7, out_valid after 64 WAIT cycles of tile 1.
- out_ready held low 10 cycles with a second cmd_valid pulsed -> out_tile/out_valid stable, cmd_ready=0, second command not captured; it is captured after handshake when re-offered.
- num_k=0 -> out_valid at c+1, out_tile=0, no ld_valid or pe_start; ld_ready delayed 4 cycles on k=1 of num_k=2 -> ld_valid held, latency +4.
- rst_n low for 1 cycle during WAIT of tile 1 -> next cycle IDLE, all outputs at reset values, pe_rst_n=0; new command completes normally.
